// File: rtl/sramlike_ram_slave_pkg.sv
// Shared types and helpers for the sram-like responder: size codes, byte-enable
// decode, the response-stage record and the arbiter grant encoding.
package sramlike_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
  } resp_stage_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_e;

  // Lane enables for a write; size 3 behaves as a full word.
  function automatic logic [3:0] sz2be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sramlike_ram_slave_if.sv
// One sram-like request/response port: the CPU side drives the master modport,
// the memory responder takes the slave modport.
interface sramlike_ram_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addrok;
  logic        dataok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addrok, dataok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addrok, dataok, rdata
  );
endinterface

// File: rtl/sramlike_ram_slave_resp_pipe.sv
// Fixed-latency response delay line for one port; the last stage is the
// registered dataok/rdata seen by the master.
module sramlike_resp_pipe
  import sramlike_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [31:0] word,
  output logic        dataok,
  output logic [31:0] rdata
);

  resp_stage_t stage_q [LATENCY];
  resp_stage_t stage_d [LATENCY];

  // Idle slots carry a zero word so rdata is 0 whenever dataok is low.
  always_comb begin
    stage_d[0].valid = push;
    stage_d[0].word  = push ? word : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= {1'b0, 32'h0};
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dataok = stage_q[LATENCY-1].valid;
  assign rdata  = stage_q[LATENCY-1].word;

endmodule

// File: rtl/sramlike_ram_slave.sv
// Memory responder for the CPU's instruction and data sram-like ports: one
// shared word RAM, data-priority arbitration with an inst starvation guard.
module sramlike_ram_slave
  import sramlike_pkg::*;
#(
  parameter int AW         = 12,
  parameter int LATENCY    = 2,
  parameter int MAX_OUT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  sramlike_ram_slave_if.slave  inst_sram,
  sramlike_ram_slave_if.slave  data_sram
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [31:0]   ram_q [2**AW];

  logic [CW-1:0] inst_cnt_q, inst_cnt_d;
  logic [CW-1:0] data_cnt_q, data_cnt_d;
  logic [SW-1:0] starve_q, starve_d;

  grant_e        grant_s;
  logic          inst_elig_s, data_elig_s;
  logic          inst_push_s, data_push_s;
  logic          sel_wr_s;
  logic [1:0]    sel_size_s;
  logic [31:0]   sel_addr_s, sel_wdata_s;
  logic [AW-1:0] idx_s;
  logic [3:0]    be_s;
  logic          we_s;
  logic [31:0]   rd_word_s, resp_word_s;
  logic          inst_dataok_s, data_dataok_s;
  logic [31:0]   inst_rdata_s, data_rdata_s;
  logic          unused_addr_s;

  // A response leaving this cycle frees its slot for an accept on the same edge.
  always_comb begin
    inst_elig_s = inst_sram.req && ((inst_cnt_q < CW'(MAX_OUT)) || inst_dataok_s);
    data_elig_s = data_sram.req && ((data_cnt_q < CW'(MAX_OUT)) || data_dataok_s);
  end

  always_comb begin
    grant_s = GNT_NONE;
    if (!resetn) begin
      grant_s = GNT_NONE;
    end else if (inst_elig_s && (!data_elig_s || (starve_q == SW'(STARVE_LIM)))) begin
      grant_s = GNT_INST;
    end else if (data_elig_s) begin
      grant_s = GNT_DATA;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if ((grant_s == GNT_INST) || !inst_elig_s) begin
      starve_d = {SW{1'b0}};
    end else if ((grant_s == GNT_DATA) && (starve_q != SW'(STARVE_LIM))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  assign inst_push_s = (grant_s == GNT_INST);
  assign data_push_s = (grant_s == GNT_DATA);

  always_comb begin
    inst_cnt_d = inst_cnt_q;
    case ({inst_push_s, inst_dataok_s})
      2'b10:   inst_cnt_d = inst_cnt_q + CW'(1);
      2'b01:   inst_cnt_d = inst_cnt_q - CW'(1);
      default: inst_cnt_d = inst_cnt_q;
    endcase
    data_cnt_d = data_cnt_q;
    case ({data_push_s, data_dataok_s})
      2'b10:   data_cnt_d = data_cnt_q + CW'(1);
      2'b01:   data_cnt_d = data_cnt_q - CW'(1);
      default: data_cnt_d = data_cnt_q;
    endcase
  end

  always_comb begin
    sel_wr_s    = data_sram.wr;
    sel_size_s  = data_sram.size;
    sel_addr_s  = data_sram.addr;
    sel_wdata_s = data_sram.wdata;
    case (grant_s)
      GNT_INST: begin
        sel_wr_s    = inst_sram.wr;
        sel_size_s  = inst_sram.size;
        sel_addr_s  = inst_sram.addr;
        sel_wdata_s = inst_sram.wdata;
      end
      default: begin
        sel_wr_s    = data_sram.wr;
        sel_size_s  = data_sram.size;
        sel_addr_s  = data_sram.addr;
        sel_wdata_s = data_sram.wdata;
      end
    endcase
  end

  always_comb begin
    idx_s       = sel_addr_s[AW+1:2];
    be_s        = sz2be(sel_size_s, sel_addr_s[1:0]);
    we_s        = (grant_s != GNT_NONE) && sel_wr_s;
    rd_word_s   = ram_q[idx_s];
    resp_word_s = sel_wr_s ? 32'h0 : rd_word_s;
  end

  assign unused_addr_s = ^sel_addr_s[31:AW+2];

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          ram_q[idx_s][8*b +: 8] <= sel_wdata_s[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_cnt_q <= {CW{1'b0}};
      data_cnt_q <= {CW{1'b0}};
      starve_q   <= {SW{1'b0}};
    end else begin
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      starve_q   <= starve_d;
    end
  end

  sramlike_resp_pipe #(.LATENCY(LATENCY)) u_inst_pipe (
    .clk    (clk),
    .resetn (resetn),
    .push   (inst_push_s),
    .word   (resp_word_s),
    .dataok (inst_dataok_s),
    .rdata  (inst_rdata_s)
  );

  sramlike_resp_pipe #(.LATENCY(LATENCY)) u_data_pipe (
    .clk    (clk),
    .resetn (resetn),
    .push   (data_push_s),
    .word   (resp_word_s),
    .dataok (data_dataok_s),
    .rdata  (data_rdata_s)
  );

  assign inst_sram.addrok = inst_push_s;
  assign inst_sram.dataok = inst_dataok_s;
  assign inst_sram.rdata  = inst_rdata_s;
  assign data_sram.addrok = data_push_s;
  assign data_sram.dataok = data_dataok_s;
  assign data_sram.rdata  = data_rdata_s;

endmodule

// File: doc/sramlike_ram_slave.md
# sramlike_ram_slave

Responder-side model for the CPU's two sram-like master ports, instruction and data. It accepts requests from both ports and arbitrates them onto one shared word-addressed RAM. Each accepted request returns data_ok after a fixed, parameterised latency. It is the memory end of the interface that `mycpu` drives, used as the bench and FPGA memory behind the core before the AXI bridge exists.

## Interface
- `AW`, 12: RAM index width; depth is 2^AW words.
- `LATENCY`, 2: cycles from accept to data_ok; legal range 1..8.
- `MAX_OUT`, 2: maximum outstanding accepted requests per port; legal range 1..LATENCY.
- `STARVE_LIM`, 4: number of consecutive data grants, while inst is waiting, that forces one inst grant.
- `clk`, in, 1: clock, rising edge.
- `resetn`, in, 1: asynchronous active-low reset.
- `inst_sram_req`, `_wr`, `_size`[1:0], `_addr`[31:0], `_wdata`[31:0]: inputs, instruction master request.
- `inst_sram_addrok`, out, 1: request accepted this cycle.
- `inst_sram_dataok`, out, 1: response valid this cycle.
- `inst_sram_rdata`, out, 32: read word.
- `data_sram_req`, `_wr`, `_size`, `_addr`, `_wdata`: inputs, data master request; same meaning as the inst port.
- `data_sram_addrok`, `data_sram_dataok`, `data_sram_rdata`: outputs; same meaning as the inst port.

## Operation
- **Handshake.** A request is accepted at the rising edge where `req & addrok` = 1. `addrok` is combinational from `req`, the arbiter state and the outstanding count. `addrok` is never 1 while `req` is 0.
- **Eligibility.** A port is eligible when `req` = 1 and its `out_cnt` < `MAX_OUT`. At most one port is granted per cycle.
- **Arbitration.**
  - Data wins when both ports are eligible, unless `starve_cnt` == `STARVE_LIM`; in that case inst wins.
  - `starve_cnt` increments on a data grant while inst is eligible but not granted.
  - `starve_cnt` clears on any inst grant, or on any cycle in which inst is not eligible.
- **Write lanes.** The byte-enable is built from `size` and `addr[1:0]`:
  - size 0: byte at `addr[1:0]`.
  - size 1: half-word at `addr[1]`; `addr[0]` is ignored.
  - size 2: all four bytes.
  - size 3: treated as size 2.
- **Write data.** `wdata` is taken lane-aligned, with no shifting.
- **RAM access.** The RAM index is `addr[AW+1:2]`; higher address bits are ignored.
  - A write updates the RAM at the accept edge.
  - A read samples the full word at the accept edge. A later-accepted read from either port therefore sees an earlier write.
- **Response pipeline.** Each port has a `LATENCY`-stage shift register carrying {valid, word}.
  - The stage-last valid bit drives `dataok`.
  - The stage-last word drives `rdata`.
  - A write returns `dataok` with `rdata` = 0.
  - Responses on each port are in accept order.
  - No backpressure exists on `dataok`; the master must take it.
- **Outstanding count.** `out_cnt` is a per-port counter of width clog2(`MAX_OUT`+1):
  - +1 on accept.
  - −1 on `dataok`.
  - Unchanged when both happen in the same cycle.
  - It never exceeds `MAX_OUT` and never wraps.
- **Reset.** Async reset clears the pipelines, `out_cnt` and `starve_cnt`.
  - All outputs are 0 during and after reset: `addrok` = 0 while `resetn` = 0, `dataok` = 0, `rdata` = 0.
  - Responses in flight when reset is asserted are discarded.
  - RAM contents are not reset.

## Timing
- Accept at edge T: `dataok` is high for exactly one cycle, in the cycle after edge T+`LATENCY`−1. With `LATENCY` = 1, `dataok` is high in the cycle right after accept.
- Throughput: one accept per cycle total across both ports. Each port can accept back-to-back when `MAX_OUT` = `LATENCY`.
- With `MAX_OUT` < `LATENCY`, a port's `addrok` drops while its `out_cnt` == `MAX_OUT`. It can reassert in the same cycle that port's `dataok` is high, because the count decrements on the same edge.
- A request held with `addrok` = 0 must stay stable; the slave does not latch unaccepted requests.

## Structure
- The shared package `sramlike_pkg` holds:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - A function `sz2be(size, addr_lo)` returning the 4-bit byte-enable.
  - The response-stage struct {valid, word}.
- One sub-module, `sramlike_resp_pipe` (parameter `LATENCY`), is instantiated once per port. Its inputs are `push` and `word`; its outputs are `dataok` and `rdata`.
- The top level holds the RAM array, the arbiter and the counters.

## Test plan
- **Single read.** Preload word[5] = 0x11223344. A data read at addr 0x14, `LATENCY` = 2, is accepted at T → `data_sram_dataok` is high in cycle T+2 with `rdata` 0x11223344. `inst_sram_dataok` stays 0.
- **Byte/half writes.** Data writes: size 0, addr 0x21, wdata 0x0000AB00; then size 1, addr 0x22, wdata 0xCDEF0000; then a read of 0x20 with word[8] preloaded to 0 → `rdata` 0xCDEFAB00.
- **Contention and starvation.** Both ports request continuously, `STARVE_LIM` = 4, `MAX_OUT` = `LATENCY` = 2 → grant pattern D D D D I repeating. Inst responses arrive in order.
- **Outstanding cap.** `MAX_OUT` = 1, `LATENCY` = 3, inst `req` held high → `addrok` in cycles 0, 3, 6…. `dataok` in cycles 3, 6…, coinciding with the next accept.
- **Read-after-write, cross port.** A data write of 0xDEADBEEF to 0x40 at T, then an inst read of 0x40 at T+1 → inst `rdata` = 0xDEADBEEF.
- **Reset mid-flight.** Two reads outstanding; `resetn` pulsed low asynchronously mid-cycle → `dataok` never asserts for them. After release, `out_cnt` = 0 and the next request gets `addrok` in its first cycle.
